// File: rtl/aes_round_ctrl.sv
// Unified AES-128/192/256 round sequencer for encrypt and decrypt.
// Optional abort input is enabled by defining AES_CTRL_ABORT_EN.
module aes_round_ctrl #(
    parameter int NR128 = 10,
    parameter int NR192 = 12,
    parameter int NR256 = 14,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             staenc,
    input  logic             stadec,
    input  logic [1:0]       keylen,
    input  logic             load_shift,
    input  logic             rcon_adv,
`ifdef AES_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] rnd,
    output logic [3:0]       rconsel,
    output logic             rndkren,
    output logic             deckeywen,
    output logic [1:0]       keysel,
    output logic [1:0]       keyadsel,
    output logic             sboxinsel,
    output logic             mixsel,
    output logic             reginsel,
    output logic             dataregen,
    output logic             shiftsel
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DKEY  = 3'd1,
        S_INIT  = 3'd2,
        S_ROUND = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0]       RCON_MAX = 4'd9;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           r_state;
    state_t           w_state_seq;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_rnd;
    logic [CNT_W-1:0] w_rnd_nxt;
    logic [CNT_W-1:0] r_nr;
    logic [CNT_W-1:0] w_nr_m1;
    logic [3:0]       r_rconsel;
    logic [3:0]       w_rconsel_nxt;
    logic             r_dec;
    logic             w_start;
    logic             w_abort_hit;
    logic             w_last_dkey;
    logic             w_busy;
    logic             w_done;
    logic             w_rndkren;
    logic             w_deckeywen;
    logic [1:0]       w_keysel;
    logic [1:0]       w_keyadsel;
    logic             w_sboxinsel;
    logic             w_mixsel;
    logic             w_reginsel;
    logic             w_data_wr;
    logic             w_shiftsel;

    function automatic logic [CNT_W-1:0] nr_of(input logic [1:0] kl);
        logic [CNT_W-1:0] nr;
        case (kl)
            2'd1:    nr = CNT_W'(NR192);
            2'd2:    nr = CNT_W'(NR256);
            default: nr = CNT_W'(NR128);
        endcase
        return nr;
    endfunction

    assign w_nr_m1     = r_nr - CNT_ONE;
    assign w_last_dkey = (r_rnd == w_nr_m1);
    assign w_start     = (r_state == S_IDLE) && (staenc || stadec);
`ifdef AES_CTRL_ABORT_EN
    assign w_abort_hit = abort && w_busy;
`else
    assign w_abort_hit = 1'b0;
`endif

    // Sequencing: next state, abort overrides any busy state
    always_comb begin
        w_state_seq = r_state;
        case (r_state)
            S_IDLE:  w_state_seq = w_start ? (staenc ? S_INIT : S_DKEY) : S_IDLE;
            S_DKEY:  w_state_seq = w_last_dkey ? S_INIT : S_DKEY;
            S_INIT:  w_state_seq = S_ROUND;
            S_ROUND: w_state_seq = (r_rnd == w_nr_m1) ? S_FINAL : S_ROUND;
            S_FINAL: w_state_seq = S_DONE;
            S_DONE:  w_state_seq = S_IDLE;
            default: w_state_seq = S_IDLE;
        endcase
        w_state_nxt = w_abort_hit ? S_IDLE : w_state_seq;
    end

    // Round counter: DKEY reuses it to count key-expansion steps
    always_comb begin
        w_rnd_nxt = r_rnd;
        if (w_start || w_abort_hit) begin
            w_rnd_nxt = CNT_ZERO;
        end else begin
            case (r_state)
                S_DKEY:  w_rnd_nxt = w_last_dkey ? CNT_ZERO : (r_rnd + CNT_ONE);
                S_INIT:  w_rnd_nxt = r_rnd + CNT_ONE;
                S_ROUND: w_rnd_nxt = r_rnd + CNT_ONE;
                S_DONE:  w_rnd_nxt = CNT_ZERO;
                default: w_rnd_nxt = r_rnd;
            endcase
        end
    end

    // Rcon index: walks up while expanding forward, back down in decrypt rounds
    always_comb begin
        w_rconsel_nxt = r_rconsel;
        if (w_start || w_abort_hit) begin
            w_rconsel_nxt = 4'd0;
        end else if (rcon_adv && w_rndkren) begin
            if (r_dec && ((r_state == S_ROUND) || (r_state == S_FINAL))) begin
                w_rconsel_nxt = (r_rconsel == 4'd0) ? 4'd0 : (r_rconsel - 4'd1);
            end else begin
                w_rconsel_nxt = (r_rconsel == RCON_MAX) ? RCON_MAX : (r_rconsel + 4'd1);
            end
        end else begin
            w_rconsel_nxt = r_rconsel;
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rnd     <= CNT_ZERO;
            r_rconsel <= 4'd0;
            r_dec     <= 1'b0;
            r_nr      <= CNT_W'(NR128);
        end else begin
            r_state   <= w_state_nxt;
            r_rnd     <= w_rnd_nxt;
            r_rconsel <= w_rconsel_nxt;
            if (w_start) begin
                r_dec <= ~staenc;
                r_nr  <= nr_of(keylen);
            end else begin
                r_dec <= r_dec;
                r_nr  <= r_nr;
            end
        end
    end

    // Datapath and key-unit controls decoded from registered state only
    always_comb begin
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rndkren   = 1'b0;
        w_deckeywen = 1'b0;
        w_keysel    = 2'd0;
        w_keyadsel  = 2'd3;
        w_sboxinsel = 1'b0;
        w_mixsel    = 1'b0;
        w_reginsel  = 1'b0;
        w_data_wr   = 1'b0;
        w_shiftsel  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_shiftsel = 1'b1;
            end
            S_DKEY: begin
                w_busy      = 1'b1;
                w_rndkren   = 1'b1;
                w_keysel    = (r_rnd == CNT_ZERO) ? 2'd0 : 2'd1;
                w_deckeywen = w_last_dkey;
            end
            S_INIT: begin
                w_busy     = 1'b1;
                w_reginsel = 1'b1;
                w_keysel   = r_dec ? 2'd3 : 2'd0;
                w_keyadsel = 2'd0;
                w_data_wr  = 1'b1;
            end
            S_ROUND: begin
                w_busy      = 1'b1;
                w_rndkren   = 1'b1;
                w_keysel    = r_dec ? 2'd2 : 2'd1;
                w_keyadsel  = 2'd1;
                w_sboxinsel = r_dec;
                w_mixsel    = r_dec;
                w_data_wr   = 1'b1;
            end
            S_FINAL: begin
                w_busy      = 1'b1;
                w_rndkren   = 1'b1;
                w_keysel    = r_dec ? 2'd2 : 2'd1;
                w_keyadsel  = 2'd2;
                w_sboxinsel = r_dec;
                w_mixsel    = r_dec;
                w_data_wr   = 1'b1;
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_shiftsel = 1'b1;
            end
        endcase
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign rnd       = r_rnd;
    assign rconsel   = r_rconsel;
    assign rndkren   = w_rndkren;
    assign deckeywen = w_deckeywen;
    assign keysel    = w_keysel;
    assign keyadsel  = w_keyadsel;
    assign sboxinsel = w_sboxinsel;
    assign mixsel    = w_mixsel;
    assign reginsel  = w_reginsel;
    assign dataregen = w_data_wr | load_shift;
    assign shiftsel  = w_shiftsel;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: cycle-indexed reference model plus
// a done-cycle scoreboard. Abort scenario runs when AES_CTRL_ABORT_EN is defined.
module tb_aes_round_ctrl;

    logic       clk;
    logic       rst;
    logic       staenc;
    logic       stadec;
    logic [1:0] keylen;
    logic       load_shift;
    logic       rcon_adv;
`ifdef AES_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       busy;
    logic       done;
    logic [3:0] rnd;
    logic [3:0] rconsel;
    logic       rndkren;
    logic       deckeywen;
    logic [1:0] keysel;
    logic [1:0] keyadsel;
    logic       sboxinsel;
    logic       mixsel;
    logic       reginsel;
    logic       dataregen;
    logic       shiftsel;

    int n_chk;
    int n_pass;
    int done_q[$];

    localparam int PH_IDLE  = 0;
    localparam int PH_DKEY  = 1;
    localparam int PH_INIT  = 2;
    localparam int PH_ROUND = 3;
    localparam int PH_FINAL = 4;
    localparam int PH_DONE  = 5;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .staenc     (staenc),
        .stadec     (stadec),
        .keylen     (keylen),
        .load_shift (load_shift),
        .rcon_adv   (rcon_adv),
`ifdef AES_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .rnd        (rnd),
        .rconsel    (rconsel),
        .rndkren    (rndkren),
        .deckeywen  (deckeywen),
        .keysel     (keysel),
        .keyadsel   (keyadsel),
        .sboxinsel  (sboxinsel),
        .mixsel     (mixsel),
        .reginsel   (reginsel),
        .dataregen  (dataregen),
        .shiftsel   (shiftsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ctl_vec();
        return {busy, done, rndkren, deckeywen, reginsel, shiftsel, keysel, keyadsel};
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_ctl"}, {22'd0, ctl_vec()}, {22'd0, 10'b0000_01_00_11});
        chk({tag, "_rnd"}, {28'd0, rnd}, 32'd0);
        chk({tag, "_rcon"}, {28'd0, rconsel}, 32'd0);
    endtask

    // One operation driven from IDLE; every cycle compared against the spec timeline.
    task automatic run_op(input logic enc, input logic dec, input logic [1:0] kl,
                          input int rc_mode, input int restart_cyc, input int abort_cyc);
        int         nr;
        int         off;
        int         last;
        int         ph;
        int         e_rnd;
        int         e_rc;
        logic       dm;
        logic [1:0] e_ks;
        logic [1:0] e_ka;
        logic [9:0] e_ctl;
        nr   = (kl == 2'd1) ? 12 : ((kl == 2'd2) ? 14 : 10);
        dm   = ~enc;
        off  = dm ? nr : 0;
        last = (abort_cyc > 0) ? abort_cyc + 1 : off + nr + 3;
        if (abort_cyc == 0) done_q.push_back(off + nr + 2);
        e_rc = 0;
        keylen = kl;
        staenc = enc;
        stadec = dec;
        for (int c = 1; c <= last; c++) begin
            tick();
            staenc   = (c == restart_cyc);
            stadec   = 1'b0;
            keylen   = kl + 2'd1;
            rcon_adv = (rc_mode == 0) ? 1'b1 : c[0];
`ifdef AES_CTRL_ABORT_EN
            abort = (c == abort_cyc);
`endif
            e_rnd = 0;
            if (abort_cyc > 0 && c > abort_cyc) begin
                ph = PH_IDLE; e_rc = 0;
            end else if (dm && c <= nr) ph = PH_DKEY;
            else if (c == off + 1) ph = PH_INIT;
            else if (c <= off + nr) begin ph = PH_ROUND; e_rnd = c - off - 1; end
            else if (c == off + nr + 1) begin ph = PH_FINAL; e_rnd = nr; end
            else if (c == off + nr + 2) ph = PH_DONE;
            else ph = PH_IDLE;
            case (ph)
                PH_DKEY:  e_ks = (c == 1) ? 2'd0 : 2'd1;
                PH_INIT:  e_ks = dm ? 2'd3 : 2'd0;
                PH_ROUND: e_ks = dm ? 2'd2 : 2'd1;
                PH_FINAL: e_ks = dm ? 2'd2 : 2'd1;
                default:  e_ks = 2'd0;
            endcase
            e_ka  = (ph == PH_INIT) ? 2'd0 : (ph == PH_ROUND) ? 2'd1 : (ph == PH_FINAL) ? 2'd2 : 2'd3;
            e_ctl = {(ph >= PH_DKEY && ph <= PH_FINAL), (ph == PH_DONE),
                     (ph == PH_DKEY || ph == PH_ROUND || ph == PH_FINAL),
                     (ph == PH_DKEY && c == nr), (ph == PH_INIT), (ph == PH_IDLE), e_ks, e_ka};
            chk($sformatf("ctl_c%0d", c), {22'd0, ctl_vec()}, {22'd0, e_ctl});
            chk($sformatf("rcon_c%0d", c), {28'd0, rconsel}, e_rc);
            if (ph != PH_DKEY && ph != PH_DONE) chk($sformatf("rnd_c%0d", c), {28'd0, rnd}, e_rnd);
            if (ph == PH_ROUND || ph == PH_FINAL) chk("sbox_mix", {30'd0, sboxinsel, mixsel}, {30'd0, dm, dm});
            if (ph == PH_INIT) chk("dreg_init", {31'd0, dataregen}, 32'd1);
            if (ph == PH_DKEY) chk("dreg_dkey", {31'd0, dataregen}, 32'd0);
            if (done === 1'b1) begin
                chk("done_q", done_q.size(), 32'd1);
                if (done_q.size() > 0) chk("done_cyc", c, done_q.pop_front());
            end
            if ((ph == PH_DKEY || ph == PH_ROUND || ph == PH_FINAL) && rcon_adv) begin
                if (dm && (ph == PH_ROUND || ph == PH_FINAL)) e_rc = (e_rc > 0) ? e_rc - 1 : 0;
                else e_rc = (e_rc < 9) ? e_rc + 1 : 9;
            end
        end
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        staenc = 1'b0;
        chk("sb_left", done_q.size(), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        staenc = 1'b0;
        stadec = 1'b0;
        keylen = 2'd0;
        load_shift = 1'b0;
        rcon_adv = 1'b0;
`ifdef AES_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        check_idle("por");
        chk("por_dreg", {31'd0, dataregen}, 32'd0);
        rst = 1'b0;
        tick();

        // Reset asserted in the middle of an encrypt
        rcon_adv = 1'b1;
        staenc = 1'b1;
        tick();
        staenc = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_rcon", {28'd0, rconsel}, 32'd2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("rst%0d", i));
        end
        rst = 1'b0;
        tick();
        check_idle("post_rst");

        // load_shift pulse while idle
        load_shift = 1'b1;
        #1;
        chk("ls_on", {31'd0, dataregen}, 32'd1);
        tick();
        load_shift = 1'b0;
        #1;
        chk("ls_off", {31'd0, dataregen}, 32'd0);
        tick();

        run_op(1'b1, 1'b0, 2'd0, 0, 0, 0);
        run_op(1'b0, 1'b1, 2'd2, 0, 0, 0);
        run_op(1'b1, 1'b1, 2'd1, 0, 5, 0);
        run_op(1'b1, 1'b0, 2'd3, 1, 0, 0);
        run_op(1'b0, 1'b1, 2'd1, 1, 0, 0);
`ifdef AES_CTRL_ABORT_EN
        run_op(1'b0, 1'b1, 2'd0, 0, 0, 6);
        run_op(1'b1, 1'b0, 2'd0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Unified AES round sequencer. Replaces the separate encrypt/decrypt FSM pair with one parametrised FSM.
- Supports AES-128/192/256 through a per-operation key-length select.
- Drives datapath mux selects, key-schedule enables, rcon index and a start/busy/done handshake to the round datapath and the key-expansion unit.

Parameters:
- NR128, 10: round count for keylen=0 and for reserved keylen=3.
- NR192, 12: round count for keylen=1.
- NR256, 14: round count for keylen=2.
- CNT_W, 4: width of the round counter. Must be at least clog2(max NR + 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- staenc  in  1  encrypt start pulse
- stadec  in  1  decrypt start pulse
- keylen  in  2  key length; sampled with the start pulse
- load_shift  in  1  external data-register load request while idle
- rcon_adv  in  1  key unit requests an rcon step
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- rnd  out  CNT_W  current round index
- rconsel  out  4  rcon index
- rndkren  out  1  round-key register enable
- deckeywen  out  1  write stored decrypt (last) key
- keysel  out  2  0=cipher key, 1=forward expansion, 2=inverse expansion, 3=stored decrypt key
- keyadsel  out  2  0=input^key, 1=mix path, 2=shift/sbox path (final round), 3=hold
- sboxinsel  out  1  0=forward S-box, 1=inverse S-box
- mixsel  out  1  0=MixColumns, 1=InvMixColumns
- reginsel  out  1  1=load input block, 0=round feedback
- dataregen  out  1  data register enable; equals internal write OR load_shift
- shiftsel  out  1  1 in IDLE, else 0

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset, effective at the next clk edge including mid-operation:
  - state=IDLE, rnd=0, rconsel=0, mode=enc, Nr latch=NR128.
  - busy=0, done=0, rndkren=0, deckeywen=0, keysel=0, keyadsel=3, sboxinsel=0, mixsel=0, reginsel=0.
  - shiftsel=1. dataregen follows load_shift.
- States: IDLE, DKEY, INIT, ROUND, FINAL, DONE. All outputs except dataregen are registered or state-decoded, with no combinational input-to-output path.
- Start acceptance:
  - IDLE only. Starts are ignored while busy=1.
  - staenc and stadec together: encrypt wins.
  - keylen is latched into Nr at acceptance (0→NR128, 1→NR192, 2→NR256, 3→NR128).
  - rconsel and rnd clear to 0 at acceptance.
- Encrypt path, with cycle 0 = start sampled:
  - Cycle 1, INIT: reginsel=1, keysel=0, keyadsel=0, dataregen=1.
  - Cycles 2..Nr, ROUND: rnd=1..Nr-1, rndkren=1, keysel=1, keyadsel=1, mixsel=0, sboxinsel=0.
  - Cycle Nr+1, FINAL: rnd=Nr, rndkren=1, keyadsel=2.
  - Cycle Nr+2, DONE: done=1, busy=0 in the same cycle. Return to IDLE on the next cycle.
- Decrypt path:
  - Cycles 1..Nr, DKEY: rndkren=1, keysel=0 in the first DKEY cycle and 1 after. Data register idle (dataregen=load_shift only). deckeywen=1 in the last DKEY cycle only.
  - Then INIT with keysel=3, then ROUND/FINAL with keysel=2, sboxinsel=1, mixsel=1.
  - done arrives at cycle 2·Nr+2.
- busy=1 in every state except IDLE and DONE.
- rconsel:
  - Increments when rcon_adv & rndkren in encrypt rounds and in DKEY. Saturates at 9.
  - Decrements on rcon_adv & rndkren in decrypt ROUND/FINAL. Saturates at 0.
- rnd never exceeds Nr. It wraps to 0 only via DONE→IDLE.
- load_shift during busy still forces dataregen=1. Data corruption in that case is the integrator's responsibility.

Optional Feature:
- Macro: AES_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in any busy state forces IDLE at the next edge.
  - No done pulse is issued; rnd and rconsel are cleared.
  - abort is ignored in IDLE and DONE.
  - abort together with a start in IDLE: the start is accepted.
- Undefined: no abort port. An operation always runs to DONE unless rst is asserted.

Test Plan:
- Reset: rst high 3 cycles mid-encrypt → next cycle state IDLE, shiftsel=1, busy=0, rnd=0, rconsel=0, done=0.
- Encrypt keylen=0, rcon_adv tied 1: staenc pulse → done at cycle 12; rnd sequence 1..10; rconsel reaches 9 and holds; rndkren high cycles 2..11.
- Decrypt keylen=2: stadec pulse → deckeywen single pulse at cycle 14; done at cycle 30; keysel=3 at cycle 15; sboxinsel=mixsel=1 during rounds.
- Contention: staenc=stadec=1 with keylen=1 → encrypt runs, done at cycle 14. A second staenc at cycle 5 is ignored, giving exactly one done.
- Reserved keylen=3 encrypt → behaves as AES-128, done at cycle 12. load_shift pulse in IDLE → dataregen=1 for that cycle only.
- Abort (macro defined): abort at cycle 6 of a decrypt → IDLE at cycle 7, no done, busy=0. Then staenc is accepted normally.
